// File: rtl/icap_pkg.sv
// icap_pkg: shared state encoding, ICAP word constants and the per-byte bit-reversal helper.
package icap_pkg;
  typedef enum logic [2:0] {WAIT_AVAIL, IDLE, WRITE, TURN_RD, READ, TURN_WR} icap_state_e;
  localparam logic [31:0] SYNC_WORD = 32'hAA995566;
  localparam logic [31:0] DUMMY_WORD = 32'hFFFFFFFF;
  function automatic logic [31:0] bitswap32(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = x[8*b+7-i];
    return r;
  endfunction
endpackage

// File: rtl/icap_rd_pipe.sv
// icap_rd_pipe: valid-tag shift register matching the ICAPE3 readback latency, with empty/last flags.
module icap_rd_pipe
  import icap_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  output logic valid_out,
  output logic last,
  output logic empty
);
  localparam logic [DEPTH-1:0] MSB = DEPTH'(1) << (DEPTH - 1);
  logic [DEPTH-1:0] tags;
  always_ff @(posedge clk)
    if (reset) tags <= '0;
    else tags <= (tags << 1) | DEPTH'(push);
  assign valid_out = tags[DEPTH-1];
  assign empty = tags == '0;
  // the emerging tag is the only one still in flight
  assign last = tags == MSB;
endmodule

// File: rtl/icap_cmd_sequencer.sv
// icap_cmd_sequencer: ICAPE3 write/readback sequencer with turnaround and per-byte bit-reversal.
// Define ICAP_STATS_EN to add saturating wr_count/rd_count word counters.
module icap_cmd_sequencer
  import icap_pkg::*;
#(
  parameter int READ_LATENCY = 3,
  parameter int TURNAROUND = 2,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             rd_req,
  input  logic [LEN_W-1:0] rd_len,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             rd_done,
  output logic             busy,
  input  logic             icap_avail,
  input  logic [31:0]      icap_o,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_i
`ifdef ICAP_STATS_EN
  ,
  output logic [31:0]      wr_count,
  output logic [31:0]      rd_count
`endif
);
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TURNAROUND - 1);
  icap_state_e state, nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic pipe_out, pipe_last, pipe_empty, zero_done;
  assign wr_ready = (state == IDLE && !rd_req) || state == WRITE;
  assign busy = state != IDLE;
  assign rd_valid = pipe_out;
  assign rd_data = pipe_out ? bitswap32(icap_o) : '0;
  assign rd_done = zero_done || (state == TURN_WR && pipe_last);
  always_comb begin
    nxt = state;
    tcnt_nxt = tcnt;
    rem_nxt = rem;
    case (state)
      WAIT_AVAIL: nxt = icap_avail ? IDLE : WAIT_AVAIL;
      IDLE: begin
        nxt = rd_req ? (rd_len != '0 ? TURN_RD : IDLE) : (wr_valid ? WRITE : IDLE);
        tcnt_nxt = T_LOAD;
        rem_nxt = rd_len;
      end
      WRITE: nxt = wr_valid ? WRITE : IDLE;
      TURN_RD: begin
        nxt = tcnt == '0 ? READ : TURN_RD;
        tcnt_nxt = tcnt - 1'b1;
      end
      READ: begin
        nxt = rem == LEN_W'(1) ? TURN_WR : READ;
        rem_nxt = rem - 1'b1;
        tcnt_nxt = T_LOAD;
      end
      TURN_WR: begin
        // turnaround only starts counting once every read word has returned
        nxt = (pipe_empty && tcnt == '0) ? IDLE : TURN_WR;
        tcnt_nxt = pipe_empty ? tcnt - 1'b1 : T_LOAD;
      end
      default: nxt = WAIT_AVAIL;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= WAIT_AVAIL;
      tcnt <= '0;
      rem <= '0;
      icap_csib <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i <= '0;
      zero_done <= 1'b0;
    end else begin
      state <= nxt;
      tcnt <= tcnt_nxt;
      rem <= rem_nxt;
      icap_csib <= !(nxt == WRITE || nxt == READ);
      icap_rdwrb <= nxt == TURN_RD || nxt == READ || nxt == TURN_WR;
      if (wr_valid && wr_ready) icap_i <= bitswap32(wr_data);
      zero_done <= state == IDLE && rd_req && rd_len == '0;
    end
  icap_rd_pipe #(.DEPTH(READ_LATENCY)) u_rd_pipe (
    .clk(clk),
    .reset(reset),
    .push(state == READ),
    .valid_out(pipe_out),
    .last(pipe_last),
    .empty(pipe_empty)
  );
`ifdef ICAP_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_valid && wr_ready && wr_count != '1) wr_count <= wr_count + 1'b1;
      if (rd_valid && rd_count != '1) rd_count <= rd_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_icap_cmd_sequencer.sv
// tb_icap_cmd_sequencer: randomized self-checking bench with an ICAPE3 readback model.
module tb_icap_cmd_sequencer;
  import icap_pkg::*;
  localparam int T = 2;
  localparam int L = 3;
  logic clk = 1'b0, reset = 1'b1, wr_valid = 1'b0, rd_req = 1'b0, icap_avail = 1'b0;
  logic [31:0] wr_data = '0, icap_o = '0;
  logic [15:0] rd_len = '0;
  logic wr_ready, rd_valid, rd_done, busy, icap_csib, icap_rdwrb;
  logic [31:0] rd_data, icap_i;
`ifdef ICAP_STATS_EN
  logic [31:0] wr_count, rd_count;
`endif
  int tests = 0, fails = 0;
  logic [31:0] exp_i = '0;
  logic [31:0] rd_n = '0, seq_base = '0, salt = '0;
  bit use_seq = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [31:0] s0 = '0, s1 = '0;

  always #5 clk = ~clk;

  icap_cmd_sequencer dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_len(rd_len), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .busy(busy), .icap_avail(icap_avail), .icap_o(icap_o), .icap_csib(icap_csib),
    .icap_rdwrb(icap_rdwrb), .icap_i(icap_i)
`ifdef ICAP_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  function automatic logic [31:0] ref_swap(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[(i / 8) * 8 + 7 - i % 8];
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] n);
    return use_seq ? 32'h1000 + (n - seq_base) : (n * 32'h9E3779B1) ^ salt;
  endfunction

  // ICAPE3 readback: word for a CSIB-low read cycle appears on O three cycles later
  always @(posedge clk) begin
    v0 <= icap_csib === 1'b0 && icap_rdwrb === 1'b1;
    s0 <= ref_swap(word_of(rd_n));
    if (icap_csib === 1'b0 && icap_rdwrb === 1'b1) rd_n <= rd_n + 1;
    v1 <= v0;
    s1 <= s0;
    icap_o <= v1 ? s1 : $urandom;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL rst csib got %b exp 1", icap_csib); end
    tests++; if (icap_rdwrb !== 1'b0) begin fails++; $display("FAIL rst rdwrb got %b exp 0", icap_rdwrb); end
    tests++; if (icap_i !== 32'h0) begin fails++; $display("FAIL rst icap_i got %h exp 0", icap_i); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL rst wr_ready got %b exp 0", wr_ready); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rst rd_valid got %b exp 0", rd_valid); end
    tests++; if (rd_done !== 1'b0) begin fails++; $display("FAIL rst rd_done got %b exp 0", rd_done); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst busy got %b exp 1", busy); end
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rst rd_data got %h exp 0", rd_data); end
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick;
      tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL avail_wait csib c%0d got %b exp 1", c, icap_csib); end
      tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL avail_wait wr_ready c%0d got %b exp 0", c, wr_ready); end
    end
    icap_avail = 1'b1;
    tick;
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL idle wr_ready got %b exp 1", wr_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle busy got %b exp 0", busy); end
    icap_avail = 1'b0;
    tick;
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL avail_drop wr_ready got %b exp 1", wr_ready); end
    exp_i = '0;
  endtask

  task automatic test_known_writes;
    logic [31:0] w [3];
    logic [31:0] e [3];
    w = '{DUMMY_WORD, SYNC_WORD, 32'h30008001};
    e = '{32'hFFFFFFFF, 32'h5599AA66, 32'h0C000180};
    wr_valid = 1'b1;
    wr_data = w[0];
    for (int k = 0; k < 3; k++) begin
      tick;
      tests++; if (icap_i !== e[k]) begin fails++; $display("FAIL kw icap_i w%0d got %h exp %h", k, icap_i, e[k]); end
      tests++; if (icap_csib !== 1'b0) begin fails++; $display("FAIL kw csib w%0d got %b exp 0", k, icap_csib); end
      tests++; if (icap_rdwrb !== 1'b0) begin fails++; $display("FAIL kw rdwrb w%0d got %b exp 0", k, icap_rdwrb); end
      if (k < 2) wr_data = w[k+1];
      else wr_valid = 1'b0;
    end
    tick;
    tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL kw end csib got %b exp 1", icap_csib); end
    tests++; if (icap_i !== e[2]) begin fails++; $display("FAIL kw hold icap_i got %h exp %h", icap_i, e[2]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL kw end busy got %b exp 0", busy); end
    exp_i = e[2];
  endtask

  task automatic test_back_to_back(input int cycles);
    logic v;
    logic [31:0] d;
    for (int c = 0; c < cycles; c++) begin
      v = ($urandom % 4) != 0;
      d = $urandom;
      wr_valid = v;
      wr_data = d;
      tick;
      if (v) exp_i = ref_swap(d);
      tests++; if (icap_csib !== !v) begin fails++; $display("FAIL b2b csib c%0d got %b exp %b", c, icap_csib, !v); end
      tests++; if (icap_i !== exp_i) begin fails++; $display("FAIL b2b icap_i c%0d got %h exp %h", c, icap_i, exp_i); end
      tests++; if (icap_rdwrb !== 1'b0) begin fails++; $display("FAIL b2b rdwrb c%0d got %b exp 0", c, icap_rdwrb); end
      tests++; if (busy !== v) begin fails++; $display("FAIL b2b busy c%0d got %b exp %b", c, busy, v); end
      tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL b2b wr_ready c%0d got %b exp 1", c, wr_ready); end
    end
    wr_valid = 1'b0;
    tick;
    tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL b2b end csib got %b exp 1", icap_csib); end
  endtask

  task automatic run_read(input int n, input bit with_wr, input logic [31:0] wd);
    logic [31:0] start;
    int k, endc;
    logic ec, er, ev, ed;
    start = rd_n;
    k = 0;
    endc = 2 * T + n + L;
    rd_req = 1'b1;
    rd_len = 16'(n);
    if (with_wr) begin wr_valid = 1'b1; wr_data = wd; end
    #1;
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL rd req wr_ready got %b exp 0", wr_ready); end
    for (int i = 0; i <= endc; i++) begin
      tick;
      if (i == 0) begin rd_req = 1'b0; rd_len = 16'($urandom); end
      ec = !(i >= T && i < T + n);
      er = i < endc;
      ev = i >= T + L && i < T + L + n;
      ed = i == T + L + n - 1;
      tests++; if (icap_csib !== ec) begin fails++; $display("FAIL rd%0d csib cyc%0d got %b exp %b", n, i, icap_csib, ec); end
      tests++; if (icap_rdwrb !== er) begin fails++; $display("FAIL rd%0d rdwrb cyc%0d got %b exp %b", n, i, icap_rdwrb, er); end
      tests++; if (rd_valid !== ev) begin fails++; $display("FAIL rd%0d rd_valid cyc%0d got %b exp %b", n, i, rd_valid, ev); end
      tests++; if (rd_done !== ed) begin fails++; $display("FAIL rd%0d rd_done cyc%0d got %b exp %b", n, i, rd_done, ed); end
      tests++; if (busy !== er) begin fails++; $display("FAIL rd%0d busy cyc%0d got %b exp %b", n, i, busy, er); end
      tests++; if (wr_ready !== !er) begin fails++; $display("FAIL rd%0d wr_ready cyc%0d got %b exp %b", n, i, wr_ready, !er); end
      tests++; if (icap_i !== exp_i) begin fails++; $display("FAIL rd%0d icap_i cyc%0d got %h exp %h", n, i, icap_i, exp_i); end
      if (ev) begin
        tests++; if (rd_data !== word_of(start + k)) begin fails++; $display("FAIL rd%0d rd_data word%0d got %h exp %h", n, k, rd_data, word_of(start + k)); end
        k++;
      end
    end
    if (with_wr) begin
      tick;
      exp_i = ref_swap(wd);
      tests++; if (icap_i !== exp_i) begin fails++; $display("FAIL coll icap_i got %h exp %h", icap_i, exp_i); end
      tests++; if (icap_csib !== 1'b0) begin fails++; $display("FAIL coll csib got %b exp 0", icap_csib); end
      tests++; if (icap_rdwrb !== 1'b0) begin fails++; $display("FAIL coll rdwrb got %b exp 0", icap_rdwrb); end
      wr_valid = 1'b0;
      tick;
      tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL coll end csib got %b exp 1", icap_csib); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL coll end busy got %b exp 0", busy); end
    end
  endtask

  task automatic test_read_seq;
    use_seq = 1'b1;
    seq_base = rd_n;
    run_read(4, 1'b0, 32'h0);
    use_seq = 1'b0;
  endtask

  task automatic test_rd_wr_collision;
    run_read(3, 1'b1, SYNC_WORD);
  endtask

  task automatic test_zero_len;
    rd_req = 1'b1;
    rd_len = '0;
    #1;
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL zl wr_ready got %b exp 0", wr_ready); end
    tick;
    rd_req = 1'b0;
    tests++; if (rd_done !== 1'b1) begin fails++; $display("FAIL zl rd_done got %b exp 1", rd_done); end
    tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL zl csib got %b exp 1", icap_csib); end
    tests++; if (icap_rdwrb !== 1'b0) begin fails++; $display("FAIL zl rdwrb got %b exp 0", icap_rdwrb); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zl busy got %b exp 0", busy); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL zl rd_valid got %b exp 0", rd_valid); end
    tick;
    tests++; if (rd_done !== 1'b0) begin fails++; $display("FAIL zl done2 got %b exp 0", rd_done); end
    tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL zl csib2 got %b exp 1", icap_csib); end
  endtask

  task automatic test_random_reads;
    for (int b = 0; b < 6; b++) run_read($urandom_range(1, 12), b % 2 == 1, $urandom);
  endtask

  task automatic test_reset_mid_read;
    logic ev;
    rd_req = 1'b1;
    rd_len = 16'd8;
    for (int i = 0; i <= T + L + 1; i++) begin
      tick;
      if (i == 0) rd_req = 1'b0;
      ev = i >= T + L;
      tests++; if (rd_valid !== ev) begin fails++; $display("FAIL mid rd_valid cyc%0d got %b exp %b", i, rd_valid, ev); end
    end
    reset = 1'b1;
    tick;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL mid_rst rd_valid got %b exp 0", rd_valid); end
    tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL mid_rst csib got %b exp 1", icap_csib); end
    tests++; if (icap_rdwrb !== 1'b0) begin fails++; $display("FAIL mid_rst rdwrb got %b exp 0", icap_rdwrb); end
    tests++; if (rd_done !== 1'b0) begin fails++; $display("FAIL mid_rst rd_done got %b exp 0", rd_done); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_rst busy got %b exp 1", busy); end
    tests++; if (icap_i !== 32'h0) begin fails++; $display("FAIL mid_rst icap_i got %h exp 0", icap_i); end
    tick;
    icap_avail = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL post_rst rd_valid c%0d got %b exp 0", c, rd_valid); end
      tests++; if (rd_done !== 1'b0) begin fails++; $display("FAIL post_rst rd_done c%0d got %b exp 0", c, rd_done); end
    end
    icap_avail = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_rst busy got %b exp 0", busy); end
    tests++; if (icap_csib !== 1'b1) begin fails++; $display("FAIL post_rst csib got %b exp 1", icap_csib); end
    exp_i = '0;
  endtask

  initial begin
    salt = $urandom;
    test_reset;
    test_known_writes;
    test_back_to_back(40);
    test_read_seq;
    test_rd_wr_collision;
    test_zero_len;
    test_random_reads;
    test_reset_mid_read;
    test_back_to_back(20);
    run_read(5, 1'b0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
